// File: rtl/rockwave_pipe_pkg.sv
// Shared definitions for the pipeline-boundary register: mode selectors and
// the skid-buffer state encoding.
package rockwave_pipe_pkg;

    localparam int PIPE_MODE_BYPASS = 0;
    localparam int PIPE_MODE_REG    = 1;
    localparam int PIPE_MODE_SKID   = 2;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid buffer: registered in_ready, so nothing on the downstream
// side reaches in_ready within the same cycle. out_data always comes from main.
module pipe_stage_skid
    import rockwave_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_accept;
    logic w_pop;

    assign w_accept  = in_valid & r_in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // NOTE: non-blocking assignments throughout, so every branch sees the
    // pre-edge values of r_main/r_skid and the TWO->ONE move is race-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= RESET_VAL;
            r_skid      <= RESET_VAL;
        end else if (flush) begin
            // Data registers keep stale contents; they are ignored while empty.
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ONE;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_pop) begin
                        r_state    <= TWO;
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                    end else if (w_pop && !w_accept) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept && w_pop) begin
                        r_main <= in_data;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_state    <= ONE;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Pipeline-boundary register with valid/ready handshake and synchronous flush.
// MODE: 0 bypass, 1 single register, 2 skid buffer. PIPE_STAGE_STALL_CNT_EN adds stall_cnt.
module pipe_stage
    import rockwave_pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               MODE      = PIPE_MODE_REG,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    if (MODE == PIPE_MODE_BYPASS) begin : g_bypass
        assign out_valid = in_valid & ~flush;
        assign out_data  = in_data;
        assign in_ready  = out_ready | flush;
    end else if (MODE == PIPE_MODE_REG) begin : g_reg
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             w_accept;

        assign in_ready  = ~r_valid | out_ready;
        assign w_accept  = in_valid & in_ready;
        assign out_valid = r_valid;
        assign out_data  = r_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= RESET_VAL;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= in_data;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end else begin : g_skid
        pipe_stage_skid #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_skid (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    if (MODE == PIPE_MODE_BYPASS) begin : g_stall_off
        assign stall_cnt = '0;
    end else begin : g_stall
        logic [STALL_CNT_W-1:0] r_stall_cnt;

        // Saturating; flush deliberately leaves it alone.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stall_cnt <= '0;
            end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end

        assign stall_cnt = r_stall_cnt;
    end
`endif

endmodule
